// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch FSM states, instruction field positions and opcodes used by fetch and Control
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {REQ, WAIT, HOLD} fetch_state_e;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
endpackage

// File: rtl/fetch_stats.sv
// fetch_stats: wrapping counters of consumed and flushed instructions
// Ports: clk, rst_n (async active-low), fetched/flushed one-cycle event strobes,
//        stat_fetched/stat_flushed 32-bit running counts.
module fetch_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetched,
  input  logic        flushed,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed
);
  logic [31:0] fetched_q, flushed_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_q + 32'(fetched);
      flushed_q <= flushed_q + 32'(flushed);
    end
  end
  assign stat_fetched = fetched_q;
  assign stat_flushed = flushed_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner, single-outstanding instruction fetch and hold buffer for decode
// Ports: clk, rst_n (async active-low); imem_req_valid/imem_req_ready/imem_addr request channel;
//        imem_rsp_valid/imem_rsp_data response; redirect_valid/redirect_pc from branch/jump;
//        instr_valid/instr_ready handshake to decode with instr, opcode, pc_out, pc_plus4.
// Optional: FETCH_STATS_EN adds stat_fetched/stat_flushed counters.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  pc_plus4
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        stat_fetched,
  output logic [31:0]        stat_flushed
`endif
);
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_out_q, pc_out_d, tgt;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic valid_q, valid_d, discard_q, discard_d;
  assign tgt = redirect_pc & ~ADDR_W'(3);
  // discard marks an accepted request whose response must be dropped after a redirect
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_out_d  = pc_out_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    discard_d = discard_q;
    unique case (state_q)
      REQ: begin
        state_d   = imem_req_ready ? WAIT : REQ;
        discard_d = redirect_valid && imem_req_ready;
      end
      WAIT: begin
        if (redirect_valid) begin
          discard_d = !imem_rsp_valid;
          state_d   = imem_rsp_valid ? REQ : WAIT;
        end else if (imem_rsp_valid) begin
          discard_d = 1'b0;
          state_d   = discard_q ? REQ : HOLD;
          if (!discard_q) begin
            instr_d  = imem_rsp_data;
            pc_out_d = pc_q;
            pc_d     = pc_q + ADDR_W'(4);
            valid_d  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (redirect_valid || instr_ready) begin
          state_d = REQ;
          valid_d = 1'b0;
        end
      end
      default: state_d = REQ;
    endcase
    if (redirect_valid) begin
      pc_d    = tgt;
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      pc_out_q  <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_out_q  <= pc_out_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      discard_q <= discard_d;
    end
  end
  // request is suppressed while reset is asserted even though the state already sits in REQ
  assign imem_req_valid = rst_n && (state_q == REQ);
  assign imem_addr      = pc_q;
  assign instr_valid    = valid_q;
  assign instr          = instr_q;
  assign opcode         = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign pc_out         = pc_out_q;
  assign pc_plus4       = pc_out_q + ADDR_W'(4);
`ifdef FETCH_STATS_EN
  logic fetched, flushed;
  assign fetched = (state_q == HOLD) && instr_ready && !redirect_valid;
  // a flush is counted once per lost instruction: an already-discarded in-flight word is not recounted
  assign flushed = redirect_valid && ((state_q == HOLD) ||
                                      ((state_q == REQ) && imem_req_ready) ||
                                      ((state_q == WAIT) && !discard_q));
  fetch_stats u_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetched      (fetched),
    .flushed      (flushed),
    .stat_fetched (stat_fetched),
    .stat_flushed (stat_flushed)
  );
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random-walk checks of instr_fetch_unit against a transaction-level model
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_addr, imem_rsp_data, redirect_pc, instr, pc_out, pc_plus4;
  logic        redirect_valid, instr_valid, instr_ready;
  logic [5:0]  opcode;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flushed;
`endif
  int checks = 0, errors = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .opcode         (opcode),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_flushed   (stat_flushed)
`endif
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h0) ? 32'h8C08_0004 : ((a * 32'h9E37_79B1) ^ 32'h1357_9BDF);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // model: next fetch address, one outstanding request (possibly stale), one held instruction
  logic [31:0] m_pc, m_hi, m_hp;
  logic        m_out, m_stale, m_hv;
  int unsigned m_fet, m_fl;
  always @(posedge clk or negedge rst_n) begin : model
    logic acc, rsp;
    if (!rst_n) begin
      m_pc <= 32'h0; m_hi <= 32'h0; m_hp <= 32'h0;
      m_out <= 1'b0; m_stale <= 1'b0; m_hv <= 1'b0;
      m_fet <= 0; m_fl <= 0;
    end else begin
      acc = !m_out && !m_hv && imem_req_ready;
      rsp = m_out && imem_rsp_valid;
      if (redirect_valid) begin
        if (m_hv || acc || (m_out && !m_stale)) m_fl <= m_fl + 1;
        m_out   <= acc || (m_out && !rsp);
        m_stale <= acc || (m_out && !rsp);
        m_hv    <= 1'b0;
        m_pc    <= redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (m_hv && instr_ready) begin
          m_hv  <= 1'b0;
          m_fet <= m_fet + 1;
        end
        if (rsp) begin
          m_out   <= 1'b0;
          m_stale <= 1'b0;
          if (!m_stale) begin
            m_hv <= 1'b1;
            m_hi <= imem_rsp_data;
            m_hp <= m_pc;
            m_pc <= m_pc + 32'd4;
          end
        end
        if (acc) m_out <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_valid", 32'(imem_req_valid), 32'(!m_out && !m_hv));
      chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", 32'(instr_valid), 32'(m_hv));
      if (m_hv) begin
        chk("instr", instr, m_hi);
        chk("pc_out", pc_out, m_hp);
        chk("opcode", 32'(opcode), 32'(m_hi[31:26]));
        chk("pc_plus4", pc_plus4, m_hp + 32'd4);
      end
`ifdef FETCH_STATS_EN
      chk("stat_fetched", stat_fetched, m_fet);
      chk("stat_flushed", stat_flushed, m_fl);
`endif
    end
  end

  // memory responder: one response per accepted request, delay cycles after the first WAIT cycle
  logic        pend;
  int          cnt, delay;
  logic [31:0] paddr;
  task automatic step();
    logic acc;
    logic [31:0] a;
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    a = imem_addr;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (acc) begin
      pend = 1'b1;
      paddr = a;
      cnt = delay;
    end
    if (pend) begin
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = mem(paddr);
        pend = 1'b0;
      end else cnt--;
    end
  endtask

  task automatic wait_req(input string n);
    for (int i = 0; i < 20 && !imem_req_valid; i++) step();
    chk(n, 32'(imem_req_valid), 32'd1);
  endtask

  task automatic wait_valid(input string n);
    for (int i = 0; i < 20 && !instr_valid; i++) step();
    chk(n, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    delay = 0; pend = 1'b0; cnt = 0; paddr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    rst_n = 1'b1;
    // first fetch from address 0 with zero-wait memory
    #1;
    chk("s1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("s1_addr", imem_addr, 32'h0);
    step();
    chk("s1_wait_no_valid", 32'(instr_valid), 32'd0);
    step();
    chk("s1_instr_valid", 32'(instr_valid), 32'd1);
    chk("s1_instr", instr, 32'h8C08_0004);
    chk("s1_opcode", 32'(opcode), 32'h23);
    chk("s1_pc_out", pc_out, 32'h0);
    chk("s1_pc_plus4", pc_plus4, 32'h4);
    // stall in HOLD for five cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s2_hold_instr", instr, 32'h8C08_0004);
      chk("s2_hold_pc", pc_out, 32'h0);
      chk("s2_no_req", 32'(imem_req_valid), 32'd0);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("s2_next_req", 32'(imem_req_valid), 32'd1);
    chk("s2_next_addr", imem_addr, 32'h4);
    // redirect while waiting, response two cycles later is dropped
    delay = 2;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    step();
    redirect_valid = 1'b0;
    delay = 0;
    wait_req("s3_req_timeout");
    chk("s3_addr", imem_addr, 32'h40);
    chk("s3_no_valid", 32'(instr_valid), 32'd0);
    // redirect in the cycle the request is accepted
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    wait_req("s4_req_timeout");
    chk("s4_addr", imem_addr, 32'h100);
    chk("s4_no_valid", 32'(instr_valid), 32'd0);
    // redirect while holding with instr_ready high
    wait_valid("s5_valid_timeout");
    chk("s5_pc_out", pc_out, 32'h100);
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    instr_ready = 1'b0; redirect_valid = 1'b0;
    chk("s5_flushed", 32'(instr_valid), 32'd0);
    chk("s5_req", 32'(imem_req_valid), 32'd1);
    chk("s5_addr", imem_addr, 32'h200);
    // wrap at top of address space, redirect while request is not accepted
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    chk("s6_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("s6_addr_stable", imem_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    wait_valid("s6_valid_timeout");
    chk("s6_pc_out", pc_out, 32'hFFFF_FFFC);
    chk("s6_pc_plus4", pc_plus4, 32'h0);
    chk("s6_instr", instr, mem(32'hFFFF_FFFC));
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("s6_wrap_addr", imem_addr, 32'h0);
`ifdef FETCH_STATS_EN
    chk("stat_fetched_dir", stat_fetched, 32'd2);
    chk("stat_flushed_dir", stat_flushed, 32'd3);
`endif
    // random walk, checked cycle by cycle against the model
    for (int i = 0; i < 400; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      instr_ready = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc = $urandom;
      delay = $urandom_range(0, 2);
      step();
    end
    redirect_valid = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
